signal_sequencer: RTL and testbench

Controller that sits between the raw dashboard buttons and the ThunderBird light sequencer. It synchronizes and edge-detects the active-low left/right/hazard buttons and holds a latched mode (IDLE/LEFT/RIGHT/HAZARD) that toggles on each press. It drives the light block's active-low request, enable and reset pins, with a programmable step rate. Left/right modes auto-cancel after a fixed number of steps.

---
 rtl/thunderbird_pkg.sv | 18 +
 rtl/button_sync.sv | 40 ++++
 rtl/signal_sequencer.sv | 143 ++++++++++++++
 tb/tb_signal_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/thunderbird_pkg.sv
// thunderbird_pkg
// Shared definitions for the ThunderBird light controller:
//   - 2-bit mode encodings presented on the mode output
//   - default step prescale (4 Hz steps from a 50 MHz clock)
//   - default prescaler width
//   - default number of steps a turn signal runs before cancelling itself
package thunderbird_pkg;

   localparam logic [1:0] MODE_IDLE   = 2'b00;
   localparam logic [1:0] MODE_LEFT   = 2'b01;
   localparam logic [1:0] MODE_RIGHT  = 2'b10;
   localparam logic [1:0] MODE_HAZARD = 2'b11;

   localparam int DEFAULT_TICK_DIV          = 12_500_000;
   localparam int DEFAULT_CNT_W             = 24;
   localparam int DEFAULT_AUTO_CANCEL_TICKS = 40;

endpackage

// File: rtl/button_sync.sv
// button_sync
// Brings one raw active-low button into the clk domain and turns each press
// (a 1->0 transition of the synchronized level) into a single-cycle pulse.
// A button sampled low at edge k gives a press pulse after edge k+2.
// Ports:
//   clk    in   system clock
//   reset  in   synchronous, active-high; all flops return to "released"
//   btn_n  in   raw button, active-low, asynchronous to clk
//   press  out  one-cycle press pulse, active-high
module button_sync (
   input  logic clk,
   input  logic reset,
   input  logic btn_n,
   output logic press
);

   logic sync1_reg;
   logic sync2_reg;
   logic prev_reg;
   logic press_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_reg <= 1'b1;
         sync2_reg <= 1'b1;
         prev_reg  <= 1'b1;
         press_reg <= 1'b0;
      end else begin
         sync1_reg <= btn_n;
         sync2_reg <= sync1_reg;
         prev_reg  <= sync2_reg;
         // Registered edge detect: a held button only produces one pulse
         // because prev_reg follows the low level on the next edge.
         press_reg <= prev_reg & ~sync2_reg;
      end
   end

   assign press = press_reg;

endmodule

// File: rtl/signal_sequencer.sv
// signal_sequencer
// Front end for the ThunderBird light sequencer. Debounced-by-sync press
// pulses from the left/right/hazard buttons toggle a latched mode; the mode is
// decoded into the light block's active-low request pins. A prescaler produces
// the light_enable step strobe, and LEFT/RIGHT cancel themselves after
// AUTO_CANCEL_TICKS steps. Every mode change restarts the prescaler and step
// counter and pulses light_reset_n low for one cycle.
// Ports:
//   clk             in   system clock
//   reset           in   synchronous, active-high
//   left_btn_n      in   raw left button, active-low
//   right_btn_n     in   raw right button, active-low
//   hazard_btn_n    in   raw hazard button, active-low
//   light_left_n    out  left request to light block, active-low
//   light_right_n   out  right request to light block, active-low
//   light_hazard_n  out  hazard request to light block, active-low
//   light_enable    out  one-cycle step strobe
//   light_reset_n   out  light block reset, active-low
//   mode            out  current mode (IDLE/LEFT/RIGHT/HAZARD)
module signal_sequencer
   import thunderbird_pkg::*;
#(
   parameter int TICK_DIV          = DEFAULT_TICK_DIV,
   parameter int CNT_W             = DEFAULT_CNT_W,
   parameter int AUTO_CANCEL_TICKS = DEFAULT_AUTO_CANCEL_TICKS
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       left_btn_n,
   input  logic       right_btn_n,
   input  logic       hazard_btn_n,
   output logic       light_left_n,
   output logic       light_right_n,
   output logic       light_hazard_n,
   output logic       light_enable,
   output logic       light_reset_n,
   output logic [1:0] mode
);

   // Sized to hold AUTO_CANCEL_TICKS-1 even when AUTO_CANCEL_TICKS is 1.
   localparam int               STEP_W    = $clog2(AUTO_CANCEL_TICKS + 1);
   localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(AUTO_CANCEL_TICKS - 1);

   // Button index: 0 = left, 1 = right, 2 = hazard.
   logic [2:0] btn_n_vec;
   logic [2:0] press_vec;

   assign btn_n_vec = {hazard_btn_n, right_btn_n, left_btn_n};

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_btn
         button_sync u_sync (
            .clk   (clk),
            .reset (reset),
            .btn_n (btn_n_vec[gi]),
            .press (press_vec[gi])
         );
      end
   endgenerate

   logic [CNT_W-1:0]  presc_reg, presc_next;
   logic [STEP_W-1:0] step_reg, step_next;
   logic [1:0]        mode_reg, mode_next;
   logic              light_left_n_reg, light_right_n_reg, light_hazard_n_reg;
   logic              light_enable_reg, light_reset_n_reg;
   logic              tick;
   logic              in_turn;
   logic              mode_change;
   logic              left_p, right_p, hazard_p;

   assign left_p   = press_vec[0];
   assign right_p  = press_vec[1];
   assign hazard_p = press_vec[2];

   always_comb begin
      tick      = (presc_reg == TICK_LAST);
      in_turn   = (mode_reg == MODE_LEFT) || (mode_reg == MODE_RIGHT);
      mode_next = mode_reg;

      if (hazard_p) begin
         mode_next = (mode_reg == MODE_HAZARD) ? MODE_IDLE : MODE_HAZARD;
      end else if (mode_reg == MODE_HAZARD) begin
         mode_next = MODE_HAZARD;
      end else if (left_p && !right_p) begin
         mode_next = (mode_reg == MODE_LEFT) ? MODE_IDLE : MODE_LEFT;
      end else if (right_p && !left_p) begin
         mode_next = (mode_reg == MODE_RIGHT) ? MODE_IDLE : MODE_RIGHT;
      end else if (in_turn && tick && (step_reg == STEP_LAST)) begin
         // A simultaneous left+right press is a no-op, so it lands here and
         // does not hold off the auto-cancel.
         mode_next = MODE_IDLE;
      end

      mode_change = (mode_next != mode_reg);

      if (mode_change || tick) begin
         presc_next = '0;
      end else begin
         presc_next = presc_reg + 1'b1;
      end

      if (mode_change || !in_turn) begin
         step_next = '0;
      end else if (tick) begin
         step_next = step_reg + 1'b1;
      end else begin
         step_next = step_reg;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mode_reg           <= MODE_IDLE;
         presc_reg          <= '0;
         step_reg           <= '0;
         light_left_n_reg   <= 1'b1;
         light_right_n_reg  <= 1'b1;
         light_hazard_n_reg <= 1'b1;
         light_enable_reg   <= 1'b0;
         light_reset_n_reg  <= 1'b0;
      end else begin
         mode_reg           <= mode_next;
         presc_reg          <= presc_next;
         step_reg           <= step_next;
         // Decode from mode_next so the requests change on the same edge
         // as mode and the light_reset_n pulse.
         light_left_n_reg   <= (mode_next != MODE_LEFT);
         light_right_n_reg  <= (mode_next != MODE_RIGHT);
         light_hazard_n_reg <= (mode_next != MODE_HAZARD);
         light_enable_reg   <= tick;
         light_reset_n_reg  <= ~mode_change;
      end
   end

   assign mode           = mode_reg;
   assign light_left_n   = light_left_n_reg;
   assign light_right_n  = light_right_n_reg;
   assign light_hazard_n = light_hazard_n_reg;
   assign light_enable   = light_enable_reg;
   assign light_reset_n  = light_reset_n_reg;

endmodule

// File: tb/tb_signal_sequencer.sv
// tb_signal_sequencer
// Self-checking bench for signal_sequencer with TICK_DIV=4, AUTO_CANCEL_TICKS=6.
// A behavioural model tracks elapsed cycles since the last mode change and the
// sampled button history; each scenario task compares the DUT outputs with it
// every cycle and also checks the key timing points against fixed values.
module tb_signal_sequencer;

   localparam int TD = 4;
   localparam int AC = 6;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       left_btn_n = 1'b1;
   logic       right_btn_n = 1'b1;
   logic       hazard_btn_n = 1'b1;
   logic       light_left_n, light_right_n, light_hazard_n;
   logic       light_enable, light_reset_n;
   logic [1:0] mode;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   signal_sequencer #(
      .TICK_DIV          (TD),
      .CNT_W             (3),
      .AUTO_CANCEL_TICKS (AC)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .left_btn_n     (left_btn_n),
      .right_btn_n    (right_btn_n),
      .hazard_btn_n   (hazard_btn_n),
      .light_left_n   (light_left_n),
      .light_right_n  (light_right_n),
      .light_hazard_n (light_hazard_n),
      .light_enable   (light_enable),
      .light_reset_n  (light_reset_n),
      .mode           (mode)
   );

   // {mode, left_n, right_n, hazard_n, enable, reset_n}
   logic [6:0] obs_vec;
   logic [6:0] exp_vec;
   assign obs_vec = {mode, light_left_n, light_right_n, light_hazard_n,
                     light_enable, light_reset_n};

   // ---------------- reference model ----------------
   // m_c counts edges since the last mode change / reset; a step tick occurs
   // in the cycle where m_c mod TD == TD-1, and m_c/TD is the number of steps
   // already taken. hist holds the last four sampled levels per button
   // (bit 0 newest); a press takes effect three edges after the low sample.
   logic [1:0] m_mode;
   int         m_c;
   logic [3:0] hist [3];

   always @(posedge clk) begin : model
      logic [2:0] btn;
      logic [2:0] p;
      logic       tk;
      logic       chg;
      logic [1:0] nm;
      btn = {hazard_btn_n, right_btn_n, left_btn_n};
      if (reset) begin
         m_mode  <= 2'b00;
         m_c     <= 0;
         for (int b = 0; b < 3; b++) hist[b] <= 4'hF;
         exp_vec <= 7'b00_111_0_0;
      end else begin
         for (int b = 0; b < 3; b++) p[b] = hist[b][3] && !hist[b][2];
         tk = (m_c % TD) == TD - 1;
         nm = m_mode;
         if (p[2])                       nm = (m_mode == 2'b11) ? 2'b00 : 2'b11;
         else if (m_mode == 2'b11)       nm = 2'b11;
         else if (p[0] && !p[1])         nm = (m_mode == 2'b01) ? 2'b00 : 2'b01;
         else if (p[1] && !p[0])         nm = (m_mode == 2'b10) ? 2'b00 : 2'b10;
         else if ((m_mode == 2'b01 || m_mode == 2'b10) && tk && (m_c / TD) == AC - 1)
            nm = 2'b00;
         chg = (nm != m_mode);
         m_mode <= nm;
         m_c    <= chg ? 0 : m_c + 1;
         for (int b = 0; b < 3; b++) hist[b] <= {hist[b][2:0], btn[b]};
         exp_vec <= {nm, nm != 2'b01, nm != 2'b10, nm != 2'b11, tk, !chg};
      end
   end

   // Stimulus-only helper: one-cycle reset pulse, leaves buttons released.
   task automatic do_reset();
      left_btn_n = 1'b1; right_btn_n = 1'b1; hazard_btn_n = 1'b1;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      int en_cnt = 0;
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if (obs_vec !== 7'b00_111_0_0) begin
            bad++;
            $display("FAIL reset_hold cyc=%0d got=%b want=%b", i, obs_vec, 7'b00_111_0_0);
         end
      end
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         total++;
         if (obs_vec !== exp_vec) begin
            bad++;
            $display("FAIL reset_idle cyc=%0d got=%b want=%b", i, obs_vec, exp_vec);
         end
         if (i == 0) begin
            total++;
            if (light_reset_n !== 1'b1) begin
               bad++;
               $display("FAIL reset_release light_reset_n got=%b want=1", light_reset_n);
            end
         end
         if (light_enable === 1'b1) en_cnt++;
      end
      total++;
      if (mode !== 2'b00 || en_cnt != 5) begin
         bad++;
         $display("FAIL idle_enable mode=%b pulses=%0d want mode=00 pulses=5", mode, en_cnt);
      end
      $display("test_reset: enable pulses=%0d", en_cnt);
   endtask

   task automatic test_left_press();
      do_reset();
      for (int i = 0; i < 24; i++) begin
         if (i == 0)  left_btn_n = 1'b0;
         if (i == 10) left_btn_n = 1'b1;
         if (i == 15) left_btn_n = 1'b0;
         if (i == 17) left_btn_n = 1'b1;
         @(negedge clk);
         total++;
         if (obs_vec !== exp_vec) begin
            bad++;
            $display("FAIL left_press cyc=%0d got=%b want=%b", i, obs_vec, exp_vec);
         end
         if (i == 3) begin
            total++;
            if (mode !== 2'b01 || light_left_n !== 1'b0 || light_reset_n !== 1'b0) begin
               bad++;
               $display("FAIL left_entry mode=%b left_n=%b rst_n=%b want 01/0/0",
                        mode, light_left_n, light_reset_n);
            end
         end
         if (i == 4 || i == 12) begin
            total++;
            if (mode !== 2'b01 || light_reset_n !== 1'b1) begin
               bad++;
               $display("FAIL left_held cyc=%0d mode=%b rst_n=%b want 01/1",
                        i, mode, light_reset_n);
            end
         end
         if (i == 18) begin
            total++;
            if (mode !== 2'b00 || light_left_n !== 1'b1) begin
               bad++;
               $display("FAIL left_toggle_off mode=%b left_n=%b want 00/1", mode, light_left_n);
            end
         end
      end
      $display("test_left_press: mode=%b", mode);
   endtask

   task automatic test_auto_cancel();
      do_reset();
      for (int i = 0; i < 34; i++) begin
         if (i == 0) left_btn_n = 1'b0;
         if (i == 2) left_btn_n = 1'b1;
         @(negedge clk);
         total++;
         if (obs_vec !== exp_vec) begin
            bad++;
            $display("FAIL auto_cancel cyc=%0d got=%b want=%b", i, obs_vec, exp_vec);
         end
         if (i == 26) begin
            total++;
            if (mode !== 2'b01) begin
               bad++;
               $display("FAIL auto_cancel_early mode=%b want=01", mode);
            end
         end
         if (i == 27) begin
            total++;
            if (mode !== 2'b00 || light_left_n !== 1'b1 || light_reset_n !== 1'b0) begin
               bad++;
               $display("FAIL auto_cancel_edge mode=%b left_n=%b rst_n=%b want 00/1/0",
                        mode, light_left_n, light_reset_n);
            end
         end
      end
      $display("test_auto_cancel: mode=%b", mode);
   endtask

   task automatic test_hazard_priority();
      do_reset();
      for (int i = 0; i < 30; i++) begin
         if (i == 0)  right_btn_n = 1'b0;
         if (i == 2)  right_btn_n = 1'b1;
         if (i == 8)  begin hazard_btn_n = 1'b0; left_btn_n = 1'b0; end
         if (i == 10) begin hazard_btn_n = 1'b1; left_btn_n = 1'b1; end
         if (i == 16) left_btn_n = 1'b0;
         if (i == 18) left_btn_n = 1'b1;
         if (i == 24) hazard_btn_n = 1'b0;
         if (i == 26) hazard_btn_n = 1'b1;
         @(negedge clk);
         total++;
         if (obs_vec !== exp_vec) begin
            bad++;
            $display("FAIL hazard_prio cyc=%0d got=%b want=%b", i, obs_vec, exp_vec);
         end
         if (i == 6) begin
            total++;
            if (mode !== 2'b10 || light_right_n !== 1'b0) begin
               bad++;
               $display("FAIL hazard_setup mode=%b right_n=%b want 10/0", mode, light_right_n);
            end
         end
         if (i == 14 || i == 22) begin
            total++;
            if (mode !== 2'b11 || light_hazard_n !== 1'b0 || light_right_n !== 1'b1
                || light_left_n !== 1'b1) begin
               bad++;
               $display("FAIL hazard_hold cyc=%0d mode=%b haz_n=%b right_n=%b left_n=%b want 11/0/1/1",
                        i, mode, light_hazard_n, light_right_n, light_left_n);
            end
         end
         if (i == 29) begin
            total++;
            if (mode !== 2'b00 || light_hazard_n !== 1'b1) begin
               bad++;
               $display("FAIL hazard_off mode=%b haz_n=%b want 00/1", mode, light_hazard_n);
            end
         end
      end
      $display("test_hazard_priority: mode=%b", mode);
   endtask

   task automatic test_simultaneous();
      do_reset();
      for (int i = 0; i < 10; i++) begin
         if (i == 0) begin left_btn_n = 1'b0; right_btn_n = 1'b0; end
         if (i == 3) begin left_btn_n = 1'b1; right_btn_n = 1'b1; end
         @(negedge clk);
         total++;
         if (obs_vec !== exp_vec || mode !== 2'b00 || light_reset_n !== 1'b1) begin
            bad++;
            $display("FAIL simultaneous cyc=%0d got=%b want=%b (mode 00, rst_n 1)",
                     i, obs_vec, exp_vec);
         end
      end
      $display("test_simultaneous: mode=%b", mode);
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 26; i++) begin
         if (i == 0)  left_btn_n = 1'b0;
         if (i == 2)  left_btn_n = 1'b1;
         if (i == 16) reset = 1'b1;
         if (i == 17) reset = 1'b0;
         @(negedge clk);
         total++;
         if (obs_vec !== exp_vec) begin
            bad++;
            $display("FAIL reset_mid cyc=%0d got=%b want=%b", i, obs_vec, exp_vec);
         end
         if (i == 16) begin
            total++;
            if (obs_vec !== 7'b00_111_0_0) begin
               bad++;
               $display("FAIL reset_mid_edge got=%b want=%b", obs_vec, 7'b00_111_0_0);
            end
         end
         if (i == 19 || i == 20) begin
            total++;
            if (light_enable !== (i == 20)) begin
               bad++;
               $display("FAIL reset_mid_presc cyc=%0d enable=%b want=%0d",
                        i, light_enable, (i == 20));
            end
         end
      end
      $display("test_reset_mid: mode=%b", mode);
   endtask

   task automatic test_random();
      logic [2:0] lv = 3'b111;
      int         errs_before = bad;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         for (int b = 0; b < 3; b++)
            if ($urandom_range(0, 5) == 0) lv[b] = ~lv[b];
         left_btn_n   = lv[0];
         right_btn_n  = lv[1];
         hazard_btn_n = lv[2];
         reset = ($urandom_range(0, 79) == 0);
         @(negedge clk);
         total++;
         if (obs_vec !== exp_vec) begin
            bad++;
            $display("FAIL random cyc=%0d got=%b want=%b", i, obs_vec, exp_vec);
         end
      end
      reset = 1'b0;
      $display("test_random: 600 cycles, new errors=%0d", bad - errs_before);
   endtask

   initial begin
      test_reset();
      test_left_press();
      test_auto_cancel();
      test_hazard_priority();
      test_simultaneous();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
